// File: rtl/papuf_pkg.sv
// Shared types and default constants for the papuf16 sequencing controller.
package papuf_pkg;

    localparam int PAPUF_WIDTH      = 16;
    localparam int PAPUF_PULSE_CYC  = 4;
    localparam int PAPUF_SETTLE_CYC = 8;
    localparam int PAPUF_NUM_EVAL   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } papuf_ctrl_state_t;

endpackage

// File: rtl/papuf_sync.sv
// WIDTH-bit two-flop synchronizer bringing the asynchronous PUF response into clk.
module papuf_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments keep the two stages as two distinct flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/papuf_ctrl.sv
// Challenge/pulse/settle/sample sequencer for a papuf16 array.
// Define PAPUF_CTRL_MAJORITY_EN for NUM_EVAL evaluations with per-bit majority vote.
module papuf_ctrl
    import papuf_pkg::*;
#(
    parameter int WIDTH      = PAPUF_WIDTH,
    parameter int PULSE_CYC  = PAPUF_PULSE_CYC,
    parameter int SETTLE_CYC = PAPUF_SETTLE_CYC,
    parameter int NUM_EVAL   = PAPUF_NUM_EVAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_challenge,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_unstable,
    output logic             busy,
    output logic [WIDTH-1:0] puf_challenge,
    output logic             puf_pulse,
    input  logic [WIDTH-1:0] puf_response
);

    if (PULSE_CYC < 1 || SETTLE_CYC < 3 || NUM_EVAL < 1 || (NUM_EVAL % 2) == 0) begin : g_bad_param
        $error("papuf_ctrl: illegal PULSE_CYC/SETTLE_CYC/NUM_EVAL");
    end

`ifdef PAPUF_CTRL_MAJORITY_EN
    localparam int N_EVAL = NUM_EVAL;
    localparam int CNT_W  = $clog2(NUM_EVAL + 1);
    localparam logic [CNT_W-1:0] VOTE_HALF = CNT_W'(NUM_EVAL / 2);
    localparam logic [CNT_W-1:0] VOTE_ALL  = CNT_W'(NUM_EVAL);
`else
    localparam int N_EVAL = 1;
`endif

    localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int EVC_W   = $clog2(N_EVAL + 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [EVC_W-1:0] EVAL_LAST   = EVC_W'(N_EVAL - 1);

    papuf_ctrl_state_t state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [EVC_W-1:0]  eval_q, eval_d;
    logic [WIDTH-1:0]  chal_q, chal_d;
    logic              pulse_q, pulse_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              req_ready_q, req_ready_d;
    logic [WIDTH-1:0]  sync_resp;

`ifdef PAPUF_CTRL_MAJORITY_EN
    logic [WIDTH-1:0][CNT_W-1:0] ones_q, ones_d;
    logic [WIDTH-1:0]            vote_q, vote_d;
    logic [WIDTH-1:0]            unst_q, unst_d;
`else
    logic [WIDTH-1:0]            cap_q, cap_d;
`endif

    papuf_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (puf_response),
        .sync_out (sync_resp)
    );

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        eval_d  = eval_q;
        chal_d  = chal_q;
`ifdef PAPUF_CTRL_MAJORITY_EN
        ones_d  = ones_q;
        vote_d  = vote_q;
        unst_d  = unst_q;
`else
        cap_d   = cap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    chal_d  = req_challenge;
                    eval_d  = '0;
`ifdef PAPUF_CTRL_MAJORITY_EN
                    ones_d  = '0;
`endif
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                timer_d = PULSE_LOAD;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    timer_d = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
`ifdef PAPUF_CTRL_MAJORITY_EN
                for (int i = 0; i < WIDTH; i++) begin
                    ones_d[i] = ones_q[i] + CNT_W'(sync_resp[i]);
                end
`else
                cap_d = sync_resp;
`endif
                if (eval_q == EVAL_LAST) begin
`ifdef PAPUF_CTRL_MAJORITY_EN
                    // Votes include this last sample so DONE presents them immediately.
                    for (int i = 0; i < WIDTH; i++) begin
                        vote_d[i] = ones_d[i] > VOTE_HALF;
                        unst_d[i] = (ones_d[i] != '0) && (ones_d[i] != VOTE_ALL);
                    end
`endif
                    state_d = ST_DONE;
                end else begin
                    eval_d  = eval_q + 1'b1;
                    timer_d = PULSE_LOAD;
                    state_d = ST_PULSE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pulse_d     = (state_d == ST_PULSE);
        rsp_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: vote counters sit in the reset domain so an aborted request never leaks stale votes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            eval_q      <= '0;
            chal_q      <= '0;
            pulse_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef PAPUF_CTRL_MAJORITY_EN
            ones_q      <= '0;
            vote_q      <= '0;
            unst_q      <= '0;
`else
            cap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            eval_q      <= eval_d;
            chal_q      <= chal_d;
            pulse_q     <= pulse_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
`ifdef PAPUF_CTRL_MAJORITY_EN
            ones_q      <= ones_d;
            vote_q      <= vote_d;
            unst_q      <= unst_d;
`else
            cap_q       <= cap_d;
`endif
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign busy          = busy_q;
    assign puf_challenge = chal_q;
    assign puf_pulse     = pulse_q;
`ifdef PAPUF_CTRL_MAJORITY_EN
    assign rsp_data      = vote_q;
    assign rsp_unstable  = unst_q;
`else
    assign rsp_data      = cap_q;
    assign rsp_unstable  = '0;
`endif

endmodule

// File: tb/tb_papuf_ctrl.sv
// Scoreboard bench for papuf_ctrl; follows PAPUF_CTRL_MAJORITY_EN the same way the RTL does.
module tb_papuf_ctrl;

    localparam int W  = 16;
    localparam int PC = 4;
    localparam int SC = 8;
    localparam int NE = 5;
`ifdef PAPUF_CTRL_MAJORITY_EN
    localparam int NEV = NE;
`else
    localparam int NEV = 1;
`endif
    localparam int LAT = 2 + NEV * (PC + SC + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_challenge;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [W-1:0] rsp_unstable;
    logic         busy;
    logic [W-1:0] puf_challenge;
    logic         puf_pulse;
    logic [W-1:0] puf_response = '0;

    papuf_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_unstable  (rsp_unstable),
        .busy          (busy),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] chal;
        logic [W-1:0] data;
        logic [W-1:0] unst;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] eval_pat [NE];

    // Reference: count ones per bit over the evaluations actually performed, then vote.
    function automatic exp_t model(input logic [W-1:0] chal);
        exp_t e;
        e.chal = chal;
        e.data = '0;
        e.unst = '0;
        for (int b = 0; b < W; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < NEV; k++) ones += int'(eval_pat[k][b]);
            e.data[b] = (2 * ones > NEV);
            e.unst[b] = (ones != 0) && (ones != NEV);
        end
        return e;
    endfunction

    // PUF array model: each rising pulse presents the next evaluation's answer.
    int   pidx = 0;
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (req_valid && req_ready) pidx = 0;
        if (puf_pulse && !prev_pulse) begin
            if (pidx < NE) puf_response = eval_pat[pidx];
            pidx++;
        end
        prev_pulse = puf_pulse;
    end

    // Monitor: latency, pulse shape and response contents against the scoreboard.
    int t_start = 0;
    int run     = 0;
    int windows = 0;
    bit seen    = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            run     = 0;
            windows = 0;
            seen    = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                t_start = cyc;
                windows = 0;
            end
            if (puf_pulse) begin
                run++;
            end else if (run > 0) begin
                check("pulse_width", run, PC);
                windows++;
                run = 0;
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("rsp_latency", cyc - t_start, LAT);
                    check("pulse_windows", windows, NEV);
                end
                check("req_ready_in_done", req_ready, 0);
                check("busy_in_done", busy, 1);
                if (exp_q.size() == 0) begin
                    check("rsp_without_request", 1, 0);
                end else begin
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_unstable", rsp_unstable, exp_q[0].unst);
                    check("puf_challenge", puf_challenge, exp_q[0].chal);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
                if (rsp_ready) seen = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_unstable"}, rsp_unstable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_puf_challenge"}, puf_challenge, 0);
        check({tag, "_puf_pulse"}, puf_pulse, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    task automatic issue(input logic [W-1:0] chal);
        bit ok;
        exp_q.push_back(model(chal));
        @(posedge clk); #1;
        req_valid     = 1'b1;
        req_challenge = chal;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid     = 1'b0;
        req_challenge = W'($urandom);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_valid_timeout", 0, 1);
    endtask

    task automatic collect(input int delay);
        wait_valid();
        repeat (delay) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] base;
        logic [W-1:0] noise;
        int           rises;
        int           target;
        bit           ok;

        rst_n         = 1'b0;
        req_valid     = 1'b0;
        rsp_ready     = 1'b0;
        req_challenge = '0;
        for (int k = 0; k < NE; k++) eval_pat[k] = '0;

        #12;
        check_reset_outputs("por");
        @(posedge clk); #1 rst_n = 1'b1;

        // Constant array answer.
        for (int k = 0; k < NE; k++) eval_pat[k] = 16'h1234;
        issue(16'hA5C3);
        collect(0);

        // Disagreeing bits 0 and 1.
        eval_pat[0] = 16'h0001;
        eval_pat[1] = 16'h0000;
        eval_pat[2] = 16'h0003;
        eval_pat[3] = 16'h0000;
        eval_pat[4] = 16'h0001;
        issue(16'h0F0F);
        collect(0);

        // Stall in DONE with a competing request held on the input.
        for (int k = 0; k < NE; k++) eval_pat[k] = 16'hC0DE;
        issue(16'h1111);
        wait_valid();
        for (int k = 0; k < NE; k++) eval_pat[k] = 16'h5AA5;
        exp_q.push_back(model(16'h2222));
        @(posedge clk); #1;
        req_valid     = 1'b1;
        req_challenge = 16'h2222;
        repeat (20) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_req_ready", req_ready, 0);
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("first_idle_req_ready", req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        collect(1);

        // Reset in the middle of a pulse, then a fresh request.
        for (int k = 0; k < NE; k++) eval_pat[k] = 16'hFFFF;
        issue(16'h3C3C);
        target = (NEV >= 3) ? 3 : 1;
        rises  = 0;
        ok     = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (puf_pulse) begin
                rises++;
                while (puf_pulse && n < 300) begin
                    if (rises == target) break;
                    @(negedge clk);
                    n++;
                end
                if (rises == target) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        if (!ok) check("reach_target_pulse", 0, 1);
        @(posedge clk); #2;
        check("pulse_before_reset", puf_pulse, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        eval_pat[0] = 16'h00FF;
        eval_pat[1] = 16'h0000;
        eval_pat[2] = 16'h0000;
        eval_pat[3] = 16'h0000;
        eval_pat[4] = 16'h0F0F;
        issue(16'h4B4B);
        collect(0);

        // All-ones array answer.
        for (int k = 0; k < NE; k++) eval_pat[k] = 16'hFFFF;
        issue(16'h7E7E);
        collect(2);

        // Random challenges with sparse per-evaluation noise.
        repeat (6) begin
            base = W'($urandom);
            for (int k = 0; k < NE; k++) begin
                noise       = W'($urandom & $urandom & $urandom);
                eval_pat[k] = base ^ noise;
            end
            issue(W'($urandom));
            collect(int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_at_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
